// File: rtl/jtmx5k_pkg.sv
// Shared definitions for the sound-command queue: default geometry, IRQ
// spacing and the IRQ state encoding.
package jtmx5k_pkg;
  localparam int JTMX5K_AW      = 2;
  localparam int JTMX5K_IRQ_GAP = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_GAP  = 2'd2
  } irq_state_t;
endpackage

// File: rtl/jtmx5k_cmdfifo_mem.sv
// Command byte storage: 2^AW x 8 array with one write port and a registered
// read port. A read of the address being written returns the incoming byte.
module jtmx5k_cmdfifo_mem
  import jtmx5k_pkg::*;
#(
  parameter int AW = JTMX5K_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    din,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    dout
);

  logic [7:0] r_mem [0:(1<<AW)-1];
  logic [7:0] r_dout;

  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= din;
  end

  // Write-first forwarding lets a byte pushed into an empty queue show up as
  // the head on the very next clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dout <= 8'h00;
    end else if (re) begin
      r_dout <= (we && (waddr == raddr)) ? din : r_mem[raddr];
    end
  end

  assign dout = r_dout;

endmodule

// File: rtl/jtmx5k_sndcmd.sv
// Main-to-sound CPU command queue with a paced interrupt: the sound CPU sees
// one IRQ per byte, separated by at least IRQ_GAP sound clock enables.
module jtmx5k_sndcmd
  import jtmx5k_pkg::*;
#(
  parameter int AW      = JTMX5K_AW,
  parameter int IRQ_GAP = JTMX5K_IRQ_GAP
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        main_cen,
  input  logic        main_we,
  input  logic [7:0]  main_din,
  input  logic        snd_cen,
  input  logic        snd_rd,
  output logic [7:0]  snd_dout,
  output logic        snd_irq,
  output logic        empty,
  output logic        full,
  output logic        overflow,
  output logic [AW:0] count
);

  localparam int          GW       = (IRQ_GAP < 2) ? 1 : $clog2(IRQ_GAP + 1);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(1 << AW);

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_ovf;
  logic [GW-1:0] r_gap;
  irq_state_t    r_state;

  logic          w_empty;
  logic          w_full;
  logic          w_wr_req;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic [AW:0]   w_count_nxt;
  logic          w_rd_en;
  logic [AW-1:0] w_raddr;
  irq_state_t    w_state_nxt;
  logic [GW-1:0] w_gap_nxt;

  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == FULL_CNT);
  assign w_wr_req = main_we & main_cen;
  assign w_pop    = snd_rd & snd_cen & ~w_empty;
  // A pop in the same cycle frees the slot, so a write into a full queue is
  // only dropped when nothing is being read.
  assign w_push   = w_wr_req & (~w_full | w_pop);
  assign w_drop   = w_wr_req & w_full & ~w_pop;

  assign w_count_nxt = r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);

  // Refresh the head register only when a new head exists: after a pop that
  // leaves data behind, or when the first byte lands in an empty queue.
  assign w_rd_en = (w_pop & ((r_count > (AW+1)'(1)) | w_push)) | (w_push & w_empty);
  assign w_raddr = w_pop ? (r_rd_ptr + AW'(1)) : r_rd_ptr;

  jtmx5k_cmdfifo_mem #(
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (w_push),
    .waddr (r_wr_ptr),
    .din   (main_din),
    .re    (w_rd_en),
    .raddr (w_raddr),
    .dout  (snd_dout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_drop) r_ovf    <= 1'b1;
      r_count <= w_count_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_gap   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_gap   <= w_gap_nxt;
    end
  end

  // The gap ends on the IRQ_GAP-th sound tick after the acknowledging pop;
  // pushes in the meantime only decide whether the IRQ comes back.
  always_comb begin
    w_state_nxt = r_state;
    w_gap_nxt   = r_gap;
    case (r_state)
      ST_IDLE: begin
        if (w_count_nxt != '0) w_state_nxt = ST_PEND;
      end
      ST_PEND: begin
        if (w_pop) begin
          w_state_nxt = ST_GAP;
          w_gap_nxt   = GW'(IRQ_GAP);
        end
      end
      ST_GAP: begin
        if (snd_cen) begin
          if (r_gap <= GW'(1)) begin
            w_gap_nxt   = '0;
            w_state_nxt = (w_count_nxt != '0) ? ST_PEND : ST_IDLE;
          end else begin
            w_gap_nxt = r_gap - GW'(1);
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_gap_nxt   = '0;
      end
    endcase
  end

  assign snd_irq  = (r_state == ST_PEND);
  assign empty    = w_empty;
  assign full     = w_full;
  assign overflow = r_ovf;
  assign count    = r_count;

endmodule

// File: tb/tb_jtmx5k_sndcmd.sv
// Bench for jtmx5k_sndcmd: directed scenarios followed by random traffic,
// with popped bytes checked against a scoreboard queue.
module tb_jtmx5k_sndcmd;
  localparam int AW      = 2;
  localparam int DEPTH   = 1 << AW;
  localparam int IRQ_GAP = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        main_cen;
  logic        main_we;
  logic [7:0]  main_din;
  logic        snd_cen;
  logic        snd_rd;
  logic [7:0]  snd_dout;
  logic        snd_irq;
  logic        empty;
  logic        full;
  logic        overflow;
  logic [AW:0] count;

  always #5 clk = ~clk;

  jtmx5k_sndcmd #(
    .AW       (AW),
    .IRQ_GAP  (IRQ_GAP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .main_cen (main_cen),
    .main_we  (main_we),
    .main_din (main_din),
    .snd_cen  (snd_cen),
    .snd_rd   (snd_rd),
    .snd_dout (snd_dout),
    .snd_irq  (snd_irq),
    .empty    (empty),
    .full     (full),
    .overflow (overflow),
    .count    (count)
  );

  int n_vec = 0;
  int n_err = 0;

  // Scoreboard of bytes the sound CPU should read, in order.
  logic [7:0] exp_q[$];

  // Reference model: queue contents, sticky overflow, IRQ level and the
  // number of sound ticks left before the IRQ may return.
  logic [7:0] m_q[$];
  bit         m_ovf;
  bit         m_irq;
  int         m_gap;
  logic [7:0] m_dout;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, want, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    exp_q.delete();
    m_ovf  = 1'b0;
    m_irq  = 1'b0;
    m_gap  = 0;
    m_dout = 8'h00;
  endtask

  task automatic model_step(input bit we, input bit mcen, input logic [7:0] din,
                            input bit rd, input bit scen);
    int  old_n;
    int  new_n;
    bit  pop;
    bit  push;
    old_n = m_q.size();
    pop   = rd && scen && (old_n > 0);
    push  = we && mcen && ((old_n < DEPTH) || pop);
    if (we && mcen && (old_n == DEPTH) && !pop) m_ovf = 1'b1;
    if (pop) void'(m_q.pop_front());
    if (push) begin
      m_q.push_back(din);
      exp_q.push_back(din);
    end
    new_n = m_q.size();
    if ((pop && new_n > 0) || (push && old_n == 0)) m_dout = m_q[0];
    if (m_gap > 0) begin
      if (scen) begin
        m_gap--;
        if (m_gap == 0) m_irq = (new_n > 0);
      end
    end else if (m_irq) begin
      if (pop) begin
        m_irq = 1'b0;
        m_gap = IRQ_GAP;
      end
    end else begin
      m_irq = (new_n > 0);
    end
  endtask

  task automatic check_state();
    chk("count",    32'(count),    32'(m_q.size()));
    chk("empty",    32'(empty),    32'(m_q.size() == 0));
    chk("full",     32'(full),     32'(m_q.size() == DEPTH));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("snd_irq",  32'(snd_irq),  32'(m_irq));
    chk("snd_dout", 32'(snd_dout), 32'(m_dout));
  endtask

  // One clock: check the result of the previous edge, then apply new inputs.
  task automatic cyc(input bit we, input logic [7:0] din, input bit mcen,
                     input bit rd, input bit scen);
    @(posedge clk);
    #1;
    check_state();
    model_step(we, mcen, din, rd, scen);
    main_we  = we;
    main_din = din;
    main_cen = mcen;
    snd_rd   = rd;
    snd_cen  = scen;
  endtask

  task automatic idle(input int n, input bit scen);
    for (int k = 0; k < n; k++) cyc(1'b0, 8'h00, 1'b0, 1'b0, scen);
  endtask

  task automatic drain();
    for (int k = 0; k < 2 * DEPTH * (IRQ_GAP + 2); k++) cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
  endtask

  // Reset raised between edges; outputs must clear without waiting for a clock.
  task automatic async_reset();
    @(posedge clk);
    #1;
    check_state();
    main_we = 1'b0; main_cen = 1'b0; snd_rd = 1'b0; snd_cen = 1'b0; main_din = 8'h00;
    #2;
    rst = 1'b1;
    #1;
    chk("rst_irq",      32'(snd_irq),  32'd0);
    chk("rst_count",    32'(count),    32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_dout",     32'(snd_dout), 32'd0);
    chk("rst_empty",    32'(empty),    32'd1);
    chk("rst_full",     32'(full),     32'd0);
    model_reset();
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  // Monitor: a pop happens on the next edge; the byte consumed is snd_dout now.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && snd_rd && snd_cen && !empty) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL pop_data: got %0h expected nothing (scoreboard empty) at %0t", snd_dout, $time);
        end else begin
          chk("pop_data", 32'(snd_dout), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    main_we = 1'b0; main_cen = 1'b0; main_din = 8'h00; snd_rd = 1'b0; snd_cen = 1'b0;
    model_reset();
    #1;
    chk("init_irq",   32'(snd_irq), 32'd0);
    chk("init_empty", 32'(empty),   32'd1);
    chk("init_count", 32'(count),   32'd0);
    chk("init_dout",  32'(snd_dout), 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;

    // Single push raises the IRQ one clock later with the byte at the head.
    cyc(1'b1, 8'h22, 1'b1, 1'b0, 1'b0);
    idle(2, 1'b0);
    drain();

    // Overfill: the fifth byte is dropped and overflow sticks.
    async_reset();
    for (int k = 0; k < 5; k++) cyc(1'b1, 8'(8'h10 + k), 1'b1, 1'b0, 1'b0);
    idle(2, 1'b0);
    drain();

    // IRQ spacing with a sparse sound clock enable.
    async_reset();
    cyc(1'b1, 8'h31, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 8'h32, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 12; k++) cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'(k % 2));
    drain();

    // Push and read together on an empty queue: push only.
    cyc(1'b1, 8'hA5, 1'b1, 1'b1, 1'b1);
    idle(2, 1'b0);
    drain();

    // Push and pop together on a full queue: both happen, no overflow.
    async_reset();
    for (int k = 0; k < 4; k++) cyc(1'b1, 8'(8'h60 + k), 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 8'h55, 1'b1, 1'b1, 1'b1);
    idle(1, 1'b0);
    drain();

    // Reset with three queued bytes and the IRQ pending.
    for (int k = 0; k < 3; k++) cyc(1'b1, 8'(8'h70 + k), 1'b1, 1'b0, 1'b0);
    idle(2, 1'b0);
    async_reset();
    cyc(1'b1, 8'h99, 1'b1, 1'b0, 1'b0);
    drain();

    // Random traffic, with one reset in the middle.
    for (int i = 0; i < 600; i++) begin
      if (i == 300) async_reset();
      cyc(1'(($urandom % 100) < 45), 8'($urandom), 1'($urandom % 2),
          1'(($urandom % 100) < 35), 1'($urandom % 2));
    end
    drain();
    idle(1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/jtmx5k_sndcmd.md
JTMX5K_SNDCMD -- requirements
Module: jtmx5k_sndcmd

Interface
REQ-001 Parameter AW, default 2, log2 of queue depth (depth = 4 entries).
REQ-002 Parameter IRQ_GAP, default 4, snd_cen ticks the IRQ stays low after a pop before it may re-assert.
REQ-003 Port clk  input  1  system clock (24 MHz domain), sole clock.
REQ-004 Port rst  input  1  reset, asynchronous, active-high.
REQ-005 Port main_cen  input  1  main CPU clock enable; qualifies main_we.
REQ-006 Port main_we  input  1  main CPU write strobe to the sound latch address.
REQ-007 Port main_din  input  8  command byte from the main CPU.
REQ-008 Port snd_cen  input  1  sound CPU clock enable; qualifies snd_rd and the IRQ_GAP count.
REQ-009 Port snd_rd  input  1  sound CPU read strobe of the latch.
REQ-010 Port snd_dout  output  8  head-of-queue byte presented to the sound CPU.
REQ-011 Port snd_irq  output  1  interrupt request to the sound CPU, active-high level.
REQ-012 Port empty  output  1  queue holds 0 entries.
REQ-013 Port full  output  1  queue holds 2^AW entries.
REQ-014 Port overflow  output  1  sticky flag, a write was dropped.
REQ-015 Port count  output  AW+1  current number of stored entries.

Function
REQ-016 A push SHALL occur on a clk edge where main_we & main_cen & !full; the byte is stored at the write pointer, which then increments modulo 2^AW.
REQ-017 A write with full=1 SHALL be dropped, leave all pointers unchanged, and set overflow until reset.
REQ-018 A pop SHALL occur on a clk edge where snd_rd & snd_cen & !empty; the read pointer then increments modulo 2^AW.
REQ-019 A read with empty=1 SHALL change no state; snd_dout keeps its last value.
REQ-020 snd_dout SHALL be registered and show the new head entry one clk after a pop or after a push into an empty queue.
REQ-021 Simultaneous push and pop with 0 < count < 2^AW SHALL perform both and leave count unchanged.
REQ-022 Simultaneous push and pop when full SHALL perform both; no overflow is flagged.
REQ-023 Simultaneous push and pop when empty SHALL perform the push only; no bypass.
REQ-024 count SHALL be a registered value, exact every cycle; empty = (count==0), full = (count==2^AW).
REQ-025 IRQ FSM states: IDLE, PEND, GAP.
REQ-026 IDLE -> PEND on the cycle count becomes nonzero; snd_irq=1 exactly in PEND.
REQ-027 PEND -> GAP on a pop; the gap counter loads IRQ_GAP.
REQ-028 In GAP the counter decrements on each snd_cen; at 0 -> PEND if count>0, else IDLE.
REQ-029 Pushes during GAP SHALL NOT shorten the gap.

Reset
REQ-030 rst SHALL asynchronously clear pointers, count, overflow, snd_dout (8'h00), gap counter; FSM = IDLE; snd_irq=0, empty=1, full=0.
REQ-031 rst asserted mid-operation SHALL discard all queued bytes; the first push after release is treated as into an empty queue.

Structure
REQ-032 The FSM state enum and the AW/IRQ_GAP defaults SHALL live in shared package jtmx5k_pkg.
REQ-033 Storage SHALL be one sub-module, jtmx5k_cmdfifo_mem (2^AW x 8, one write port, registered read port); pointers, count and FSM stay in the top.

Verification
REQ-034 Reset, push 8'h22 -> snd_irq=1 one clk later; snd_dout=8'h22; count=1.
REQ-035 Push 8'h10,8'h11,8'h12,8'h13,8'h14 with no reads -> full=1 after the 4th; 8'h14 dropped; overflow=1; pops return 10,11,12,13 in order.
REQ-036 Queue of two bytes, pop one -> snd_irq=0 for exactly 4 snd_cen ticks, then 1 again.
REQ-037 Empty queue, same-cycle push 8'hA5 and read -> no pop; count=1; snd_dout=8'hA5 next clk.
REQ-038 Full queue, same-cycle push 8'h55 and pop -> count stays 4; overflow stays 0; 8'h55 is the last byte popped.
REQ-039 Assert rst with 3 queued bytes and FSM in PEND -> snd_irq, count, overflow and snd_dout clear immediately; empty=1.
